// File: rtl/niosii_system_sysid_checker.sv
// Reads the system-ID slave (word 0 = ID, word 1 = timestamp) after reset and on start,
// compares against build-time values. Define SYSID_RECHECK_EN for periodic re-checks.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490906208,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_PERIOD = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        autoGo_q, autoGo_d;
  logic [15:0] waitCnt_q, waitCnt_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        match_q, match_d;
  logic        timeout_q, timeout_d;
  logic        recheckHit;
  logic        stallLimit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      autoGo_q  <= 1'b1;
      waitCnt_q <= '0;
      id_q      <= '0;
      ts_q      <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      autoGo_q  <= autoGo_d;
      waitCnt_q <= waitCnt_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  assign stallLimit = (waitCnt_q == TIMEOUT_LIMIT);

  // A read state that has stalled TIMEOUT_CYCLES times spends one more cycle with the
  // strobe released, pulsing done and recording the timeout.
  always_comb begin
    state_d     = state_q;
    autoGo_d    = autoGo_q;
    waitCnt_d   = waitCnt_q;
    id_d        = id_q;
    ts_d        = ts_q;
    match_d     = match_q;
    timeout_d   = timeout_q;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (autoGo_q || start || recheckHit) begin
          autoGo_d  = 1'b0;
          waitCnt_d = '0;
          state_d   = RD_ID;
        end
      end
      RD_ID, RD_TS: begin
        busy        = 1'b1;
        avm_address = (state_q == RD_TS);
        if (stallLimit) begin
          done      = 1'b1;
          timeout_d = 1'b1;
          match_d   = 1'b0;
          state_d   = IDLE;
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            waitCnt_d = '0;
            if (state_q == RD_ID) begin
              id_d    = avm_readdata;
              state_d = RD_TS;
            end else begin
              ts_d    = avm_readdata;
              state_d = CMP;
            end
          end else begin
            waitCnt_d = waitCnt_q + 16'd1;
          end
        end
      end
      CMP: begin
        busy      = 1'b1;
        done      = 1'b1;
        match_d   = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_q == EXPECTED_TS));
        timeout_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SYSID_RECHECK_EN
  localparam logic [31:0] PERIOD_LAST = 32'(RECHECK_PERIOD - 1);

  logic [31:0] period_q, period_d;

  assign recheckHit = (state_q == IDLE) && (period_q == PERIOD_LAST);

  // Idle-time counter; any finished check or manual start restarts the period.
  always_comb begin
    period_d = period_q;
    if (done || start) begin
      period_d = '0;
    end else if (state_q == IDLE) begin
      period_d = recheckHit ? '0 : period_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end
`else
  logic unusedRecheck;
  assign unusedRecheck = ^RECHECK_PERIOD;
  assign recheckHit    = 1'b0;
`endif

  assign id_value = id_q;
  assign ts_value = ts_q;
  assign match    = match_q;
  assign timeout  = timeout_q;

endmodule
